// File: rtl/conv_line_buffer_ctrl.sv
// conv_line_buffer_ctrl: four rotating line buffers feeding one 3x3 window per cycle to the filter.
// Optional status outputs o_fill / o_busy are enabled by defining CONV_CTRL_STATUS_EN.
module conv_line_buffer_ctrl #(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W     = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [PIX_W-1:0]             i_pixel_data,
  input  logic                         i_pixel_data_valid,
  output logic [9*PIX_W-1:0]           o_pixel_data,
  output logic                         o_pixel_data_valid,
  output logic                         o_intr,
  output logic                         o_overflow
`ifdef CONV_CTRL_STATUS_EN
  ,
  output logic [$clog2(4*IMG_WIDTH):0] o_fill,
  output logic                         o_busy
`endif
);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int FILL_W = $clog2(4 * IMG_WIDTH) + 1;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(4 * IMG_WIDTH);
  localparam logic [FILL_W-1:0] FILL_RD   = FILL_W'(3 * IMG_WIDTH);

  typedef enum logic {IDLE = 1'b0, RD_LINE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [COL_W-1:0]   rd_col_q, rd_col_d;
  logic [1:0]         wr_buf_q, wr_buf_d;
  logic [1:0]         rd_buf_q, rd_buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [9*PIX_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               intr_q, intr_d;
  logic               ovf_q, ovf_d;
  logic               wr_en, rd_en;
  logic [9*PIX_W-1:0] win_word;

  logic [PIX_W-1:0] line_mem [4][IMG_WIDTH];

  // RAM contents survive reset on purpose; only the pointers restart.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      line_mem[wr_buf_q][wr_col_q] <= i_pixel_data;
    end
  end

  // Window tap (row gi, column offset gk); columns past the right edge repeat the last pixel.
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gk = 0; gk < 3; gk++) begin : g_tap
      logic [1:0]       row_buf;
      logic [COL_W:0]   col_sum;
      logic [COL_W-1:0] col_sel;
      assign row_buf = rd_buf_q + 2'(gi);
      assign col_sum = {1'b0, rd_col_q} + (COL_W+1)'(gk);
      assign col_sel = (col_sum > {1'b0, LAST_COL}) ? LAST_COL : col_sum[COL_W-1:0];
      assign win_word[PIX_W*(3*gi+gk) +: PIX_W] = line_mem[row_buf][col_sel];
    end
  end

  assign wr_en = i_pixel_data_valid && (fill_q < FILL_FULL);
  assign rd_en = (state_q == RD_LINE);

  always_comb begin
    state_d  = state_q;
    wr_col_d = wr_col_q;
    wr_buf_d = wr_buf_q;
    rd_col_d = rd_col_q;
    rd_buf_d = rd_buf_q;
    fill_d   = fill_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    intr_d   = 1'b0;
    ovf_d    = i_pixel_data_valid && !wr_en;

    if (wr_en) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_buf_d = wr_buf_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fill_q >= FILL_RD) begin
          state_d  = RD_LINE;
          rd_col_d = '0;
        end
      end
      RD_LINE: begin
        valid_d = 1'b1;
        data_d  = win_word;
        if (rd_col_q == LAST_COL) begin
          rd_col_d = '0;
          rd_buf_d = rd_buf_q + 2'd1;
          intr_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          rd_col_d = rd_col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write and a read in the same cycle cancel out.
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      wr_col_q <= '0;
      wr_buf_q <= '0;
      rd_col_q <= '0;
      rd_buf_q <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      intr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_col_q <= wr_col_d;
      wr_buf_q <= wr_buf_d;
      rd_col_q <= rd_col_d;
      rd_buf_q <= rd_buf_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      intr_q   <= intr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = valid_q;
  assign o_intr             = intr_q;
  assign o_overflow         = ovf_q;

`ifdef CONV_CTRL_STATUS_EN
  assign o_fill = fill_q;
  assign o_busy = (state_q == RD_LINE);
`endif

endmodule

// File: tb/tb_conv_line_buffer_ctrl.sv
// Directed self-checking bench for conv_line_buffer_ctrl at IMG_WIDTH=8.
// Define CONV_CTRL_STATUS_EN to also exercise o_fill / o_busy.
module tb_conv_line_buffer_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  pix;
  logic        pv;
  logic [71:0] odata;
  logic        ovalid, ointr, oovf;
`ifdef CONV_CTRL_STATUS_EN
  logic [5:0]  ofill;
  logic        obusy;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base_cyc = 0;

  logic [71:0] w_q[$];
  int          wc_q[$];
  int          ic_q[$];
  int          oc_q[$];

  conv_line_buffer_ctrl #(.IMG_WIDTH(8), .PIX_W(8)) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_pixel_data(pix),
    .i_pixel_data_valid(pv),
    .o_pixel_data(odata),
    .o_pixel_data_valid(ovalid),
    .o_intr(ointr),
    .o_overflow(oovf)
`ifdef CONV_CTRL_STATUS_EN
    ,
    .o_fill(ofill),
    .o_busy(obusy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Event recorder; cycle stamps are rising-edge counts since start_run.
  always @(negedge clk) begin
    if (ovalid === 1'b1) begin
      w_q.push_back(odata);
      wc_q.push_back(cyc - base_cyc);
    end
    if (ointr === 1'b1) ic_q.push_back(cyc - base_cyc);
    if (oovf === 1'b1) oc_q.push_back(cyc - base_cyc);
  end

  // Expected window: pixel value at (row, col) of a stream starting at base is base+8*row+col.
  function automatic logic [71:0] win(input int base, input int row, input int col);
    logic [71:0] w;
    int c;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        c = col + k;
        if (c > 7) c = 7;
        w[8*(3*r+k) +: 8] = 8'(base + 8*(row + r) + c);
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] get_w(input int i);
    if (i < w_q.size()) return w_q[i];
    return 72'hFFFF_FFFF_FFFF_FFFF_FF;
  endfunction

  function automatic int get_wc(input int i);
    if (i < wc_q.size()) return wc_q[i];
    return -1;
  endfunction

  function automatic int get_ic(input int i);
    if (i < ic_q.size()) return ic_q[i];
    return -1;
  endfunction

  function automatic int get_oc(input int i);
    if (i < oc_q.size()) return oc_q[i];
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    pv   = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
  endtask

  task automatic start_run();
    w_q.delete();
    wc_q.delete();
    ic_q.delete();
    oc_q.delete();
    base_cyc = cyc;
  endtask

  // Called at a falling edge; pixel i is captured by rising edge base_cyc+1+i.
  task automatic drive(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      pix = 8'(start + i);
      pv  = 1'b1;
      @(negedge clk);
    end
    pv = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    pv   = 1'b0;
    idle(2);
    checks++; if (odata !== 72'd0) begin errors++; $display("FAIL reset_data: got %h, expected 0", odata); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", ovalid); end
    checks++; if (ointr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b, expected 0", ointr); end
    checks++; if (oovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", oovf); end
`ifdef CONV_CTRL_STATUS_EN
    checks++; if (ofill !== 6'd0) begin errors++; $display("FAIL reset_fill: got %0d, expected 0", ofill); end
    checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", obusy); end
`endif
    rstn = 1'b1;
    idle(1);
    $display("test_reset done");
  endtask

  task automatic test_first_window();
    do_reset();
    start_run();
    drive(0, 24);
    idle(20);
    checks++; if (get_wc(0) != 26) begin errors++; $display("FAIL first_latency: got edge %0d, expected 26", get_wc(0)); end
    checks++; if (get_w(0) !== win(0, 0, 0)) begin errors++; $display("FAIL first_word: got %h, expected %h", get_w(0), win(0, 0, 0)); end
    $display("test_first_window done: %0d words", w_q.size());
  endtask

  task automatic test_full_line();
    do_reset();
    start_run();
    drive(0, 24);
    idle(20);
    checks++; if (w_q.size() != 8) begin errors++; $display("FAIL line_count: got %0d, expected 8", w_q.size()); end
    checks++; if (get_w(6) !== win(0, 0, 6)) begin errors++; $display("FAIL line_word6: got %h, expected %h", get_w(6), win(0, 0, 6)); end
    checks++; if (get_w(7) !== win(0, 0, 7)) begin errors++; $display("FAIL line_clamp: got %h, expected %h", get_w(7), win(0, 0, 7)); end
    checks++; if (get_wc(7) != 33) begin errors++; $display("FAIL line_last_edge: got %0d, expected 33", get_wc(7)); end
    checks++; if (ic_q.size() != 1) begin errors++; $display("FAIL intr_count: got %0d, expected 1", ic_q.size()); end
    checks++; if (get_ic(0) != 33) begin errors++; $display("FAIL intr_edge: got %0d, expected 33", get_ic(0)); end
    // fill is now 16: seven more pixels must not start a read, the eighth must.
    drive(24, 7);
    idle(20);
    checks++; if (w_q.size() != 8) begin errors++; $display("FAIL fill23_no_read: got %0d words, expected 8", w_q.size()); end
    drive(31, 1);
    idle(20);
    checks++; if (w_q.size() != 16) begin errors++; $display("FAIL fill24_read: got %0d words, expected 16", w_q.size()); end
    checks++; if (get_wc(8) != 74) begin errors++; $display("FAIL line1_edge: got %0d, expected 74", get_wc(8)); end
    checks++; if (get_w(8) !== win(0, 1, 0)) begin errors++; $display("FAIL line1_word0: got %h, expected %h", get_w(8), win(0, 1, 0)); end
    $display("test_full_line done: %0d words, %0d intr", w_q.size(), ic_q.size());
  endtask

  task automatic test_overflow();
    do_reset();
    start_run();
    drive(0, 100);
    idle(30);
    checks++; if (oc_q.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d, expected 2", oc_q.size()); end
    checks++; if (get_oc(0) != 89) begin errors++; $display("FAIL ovf_first_edge: got %0d, expected 89", get_oc(0)); end
    checks++; if (get_oc(1) != 98) begin errors++; $display("FAIL ovf_second_edge: got %0d, expected 98", get_oc(1)); end
    checks++; if (get_wc(56) != 89) begin errors++; $display("FAIL ovf_line7_edge: got %0d, expected 89", get_wc(56)); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (get_w(56 + k) !== win(0, 7, k)) begin
        errors++;
        $display("FAIL ovf_line7_word%0d: got %h, expected %h", k, get_w(56 + k), win(0, 7, k));
      end
    end
    $display("test_overflow done: %0d overflow pulses", oc_q.size());
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_run();
    drive(0, 48);
    idle(60);
    checks++; if (w_q.size() != 32) begin errors++; $display("FAIL b2b_count: got %0d, expected 32", w_q.size()); end
    checks++; if (ic_q.size() != 4) begin errors++; $display("FAIL b2b_intr_count: got %0d, expected 4", ic_q.size()); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (get_ic(j) != 33 + 9*j) begin errors++; $display("FAIL b2b_intr%0d_edge: got %0d, expected %0d", j, get_ic(j), 33 + 9*j); end
      checks++;
      if (get_w(8*j) !== win(0, j, 0)) begin errors++; $display("FAIL b2b_line%0d_word0: got %h, expected %h", j, get_w(8*j), win(0, j, 0)); end
    end
    checks++; if (get_wc(24) != 53) begin errors++; $display("FAIL b2b_line3_edge: got %0d, expected 53", get_wc(24)); end
    checks++; if (get_w(31) !== win(0, 3, 7)) begin errors++; $display("FAIL b2b_line3_last: got %h, expected %h", get_w(31), win(0, 3, 7)); end
    $display("test_back_to_back done: %0d words", w_q.size());
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    start_run();
    drive(0, 24);
    idle(4);
    #1;
    checks++; if (ovalid !== 1'b1 || odata !== win(0, 0, 2)) begin errors++; $display("FAIL mid_pre: got valid %b data %h, expected valid 1 data %h", ovalid, odata, win(0, 0, 2)); end
    rstn = 1'b0;
    #1;
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b, expected 0", ovalid); end
    checks++; if (odata !== 72'd0) begin errors++; $display("FAIL mid_async_data: got %h, expected 0", odata); end
    idle(2);
    rstn = 1'b1;
    idle(1);
    start_run();
    idle(30);
    checks++; if (w_q.size() != 0) begin errors++; $display("FAIL mid_no_partial: got %0d words, expected 0", w_q.size()); end
    start_run();
    drive(100, 24);
    idle(20);
    checks++; if (w_q.size() != 8) begin errors++; $display("FAIL mid_new_count: got %0d, expected 8", w_q.size()); end
    checks++; if (get_wc(0) != 26) begin errors++; $display("FAIL mid_new_edge: got %0d, expected 26", get_wc(0)); end
    checks++; if (get_w(0) !== win(100, 0, 0)) begin errors++; $display("FAIL mid_new_word: got %h, expected %h", get_w(0), win(100, 0, 0)); end
    $display("test_reset_mid_line done: %0d words", w_q.size());
  endtask

`ifdef CONV_CTRL_STATUS_EN
  task automatic test_status();
    int busy_n;
    do_reset();
    start_run();
    checks++; if (ofill !== 6'd0) begin errors++; $display("FAIL status_fill0: got %0d, expected 0", ofill); end
    drive(0, 24);
    checks++; if (ofill !== 6'd24) begin errors++; $display("FAIL status_fill24: got %0d, expected 24", ofill); end
    busy_n = 0;
    repeat (30) begin
      @(negedge clk);
      if (obusy === 1'b1) busy_n++;
    end
    checks++; if (busy_n != 8) begin errors++; $display("FAIL status_busy: got %0d cycles, expected 8", busy_n); end
    checks++; if (ofill !== 6'd16) begin errors++; $display("FAIL status_fill16: got %0d, expected 16", ofill); end
    $display("test_status done: busy %0d cycles", busy_n);
  endtask
`endif

  initial begin
    rstn = 1'b1;
    pv   = 1'b0;
    pix  = 8'd0;
    #2;
    test_reset();
    test_first_window();
    test_full_line();
    test_overflow();
    test_back_to_back();
    test_reset_mid_line();
`ifdef CONV_CTRL_STATUS_EN
    test_status();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
